// File: rtl/sev_seg_scan_ctrl.sv
// Scan controller for multiplexed common-anode 7-seg digits.
// One shared decoder, guard blanking, blink, lead-zero blanking.
module sev_seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int ON_CYCLES    = 8,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [4*NUM_DIGITS-1:0] digits_bcd,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic                    blink_tick,
    input  logic                    lz_blank,
    output logic [3:0]              bcd_out,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   digit_sel_n,
    output logic                    frame_done
);

    localparam int IW   = $clog2(NUM_DIGITS);
    localparam int MAXC = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
    localparam int CW   = $clog2(MAXC) + 1;

    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

    state_t                  state, state_d;
    logic [IW-1:0]           idx, idx_d, nxt;
    logic [CW-1:0]           cnt, cnt_d;
    logic                    phase, phase_d;
    logic [4*NUM_DIGITS-1:0] snap_bcd;
    logic [NUM_DIGITS-1:0]   snap_dp, snap_blink;
    logic                    snap_lz;
    logic                    load_snap;
    logic [3:0]              bcd_d;
    logic                    dp_d, fd_d, last, suppress;
    logic [NUM_DIGITS-1:0]   sel_d, lead_zero;

    // Bit i set when digits i..top are all zero; digit 0 never blanks.
    function automatic logic [NUM_DIGITS-1:0] lz_mask(
        input logic [4*NUM_DIGITS-1:0] d
    );
        logic z;
        z = 1'b1;
        lz_mask = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            z = z & (d[4*i +: 4] == 4'd0);
            lz_mask[i] = z;
        end
    endfunction

    assign lead_zero = lz_mask(snap_bcd);
    assign last      = (idx == IW'(NUM_DIGITS - 1));
    assign nxt       = idx + IW'(1);

    always_comb begin
        state_d   = state;
        idx_d     = idx;
        cnt_d     = cnt;
        bcd_d     = bcd_out;
        dp_d      = dp_out;
        fd_d      = 1'b0;
        load_snap = 1'b0;
        phase_d   = phase ^ blink_tick;
        suppress  = (snap_blink[idx] & phase_d) |
                    (snap_lz & lead_zero[idx]);
        if (!en) begin
            state_d = IDLE;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    state_d   = BLANK;
                    idx_d     = '0;
                    cnt_d     = CW'(BLANK_CYCLES - 1);
                    load_snap = 1'b1;
                    bcd_d     = digits_bcd[3:0];
                    dp_d      = dp_mask[0];
                end
                BLANK: begin
                    if (cnt == '0) begin
                        state_d = SHOW;
                        cnt_d   = CW'(ON_CYCLES - 1);
                    end else begin
                        cnt_d = cnt - CW'(1);
                    end
                end
                SHOW: begin
                    if (cnt != '0) begin
                        cnt_d = cnt - CW'(1);
                    end else begin
                        state_d = BLANK;
                        cnt_d   = CW'(BLANK_CYCLES - 1);
                        if (last) begin
                            idx_d     = '0;
                            fd_d      = 1'b1;
                            load_snap = 1'b1;
                            bcd_d     = digits_bcd[3:0];
                            dp_d      = dp_mask[0];
                        end else begin
                            idx_d = nxt;
                            bcd_d = snap_bcd[{nxt, 2'b00} +: 4];
                            dp_d  = snap_dp[nxt];
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        sel_d = '1;
        if (state_d == SHOW && !suppress) sel_d[idx] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            cnt         <= '0;
            phase       <= 1'b0;
            snap_bcd    <= '0;
            snap_dp     <= '0;
            snap_blink  <= '0;
            snap_lz     <= 1'b0;
            bcd_out     <= '0;
            dp_out      <= 1'b0;
            digit_sel_n <= '1;
            frame_done  <= 1'b0;
        end else begin
            state       <= state_d;
            idx         <= idx_d;
            cnt         <= cnt_d;
            phase       <= phase_d;
            bcd_out     <= bcd_d;
            dp_out      <= dp_d;
            digit_sel_n <= sel_d;
            frame_done  <= fd_d;
            if (load_snap) begin
                snap_bcd   <= digits_bcd;
                snap_dp    <= dp_mask;
                snap_blink <= blink_mask;
                snap_lz    <= lz_blank;
            end
        end
    end

endmodule

// File: tb/tb_sev_seg_scan_ctrl.sv
// Directed bench for sev_seg_scan_ctrl (4 digits, 8 on, 2 blank).
// Cycle k counts rising edges since the last reset release.
module tb_sev_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [15:0] digits_bcd;
    logic [3:0]  dp_mask;
    logic [3:0]  blink_mask;
    logic        blink_tick;
    logic        lz_blank;
    logic [3:0]  bcd_out;
    logic        dp_out;
    logic [3:0]  digit_sel_n;
    logic        frame_done;

    int total = 0;
    int bad   = 0;
    int k     = 0;

    sev_seg_scan_ctrl #(
        .NUM_DIGITS  (4),
        .ON_CYCLES   (8),
        .BLANK_CYCLES(2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .digits_bcd (digits_bcd),
        .dp_mask    (dp_mask),
        .blink_mask (blink_mask),
        .blink_tick (blink_tick),
        .lz_blank   (lz_blank),
        .bcd_out    (bcd_out),
        .dp_out     (dp_out),
        .digit_sel_n(digit_sel_n),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s k=%0d observed=%0h expected=%0h",
                     tag, k, obs, exp);
            $error("%s", tag);
        end
    endtask

    task automatic goto_k(input int t);
        while (k < t) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] sel,
                           input logic [3:0] bcd);
        chk({tag, ".sel"}, 32'(digit_sel_n), 32'(sel));
        chk({tag, ".bcd"}, 32'(bcd_out), 32'(bcd));
    endtask

    initial begin
        rst_n      = 1'b0;
        en         = 1'b0;
        digits_bcd = 16'h0;
        dp_mask    = 4'h0;
        blink_mask = 4'h0;
        blink_tick = 1'b0;
        lz_blank   = 1'b0;
        repeat (2) @(negedge clk);
        chk_out("rst", 4'hF, 4'h0);
        chk("rst.dp", 32'(dp_out), 32'd0);
        chk("rst.fd", 32'(frame_done), 32'd0);

        // basic scan
        rst_n      = 1'b1;
        en         = 1'b1;
        digits_bcd = 16'h1234;
        k          = 0;
        goto_k(1);  chk_out("s0.blank", 4'hF, 4'h4);
        goto_k(2);  chk_out("s0.blank2", 4'hF, 4'h4);
        goto_k(3);  chk_out("s0.show", 4'hE, 4'h4);
        goto_k(10); chk_out("s0.end", 4'hE, 4'h4);
        goto_k(11); chk_out("s1.blank", 4'hF, 4'h3);
        goto_k(13); chk_out("s1.show", 4'hD, 4'h3);
        goto_k(23); chk_out("s2.show", 4'hB, 4'h2);
        goto_k(33); chk_out("s3.show", 4'h7, 4'h1);
        goto_k(40); chk("fd.before", 32'(frame_done), 32'd0);
        goto_k(41); chk("fd.pulse", 32'(frame_done), 32'd1);
        chk_out("f2.blank", 4'hF, 4'h4);
        goto_k(42); chk("fd.after", 32'(frame_done), 32'd0);

        // snapshot holds mid-frame
        goto_k(62); digits_bcd = 16'h9999;
        goto_k(63); chk_out("snap.d2", 4'hB, 4'h2);
        goto_k(73); chk_out("snap.d3", 4'h7, 4'h1);
        goto_k(81); chk("snap.fd", 32'(frame_done), 32'd1);
        goto_k(83); chk_out("snap.new", 4'hE, 4'h9);

        // leading-zero blanking
        goto_k(90);
        lz_blank   = 1'b1;
        digits_bcd = 16'h0040;
        goto_k(123); chk_out("lz.d0", 4'hE, 4'h0);
        goto_k(133); chk_out("lz.d1", 4'hD, 4'h4);
        goto_k(143); chk_out("lz.d2", 4'hF, 4'h0);
        goto_k(153); chk_out("lz.d3", 4'hF, 4'h0);
        goto_k(155); digits_bcd = 16'h0000;
        goto_k(163); chk_out("lz0.d0", 4'hE, 4'h0);
        goto_k(173); chk_out("lz0.d1", 4'hF, 4'h0);
        goto_k(183); chk_out("lz0.d2", 4'hF, 4'h0);
        goto_k(193); chk_out("lz0.d3", 4'hF, 4'h0);

        // blink and decimal point
        goto_k(195);
        lz_blank   = 1'b0;
        digits_bcd = 16'h1234;
        blink_mask = 4'b0010;
        dp_mask    = 4'b0100;
        goto_k(203); chk_out("bl.d0", 4'hE, 4'h4);
        chk("bl.d0dp", 32'(dp_out), 32'd0);
        goto_k(205); blink_tick = 1'b1;
        goto_k(206); blink_tick = 1'b0;
        goto_k(213); chk_out("bl.d1off", 4'hF, 4'h3);
        goto_k(223); chk_out("bl.d2", 4'hB, 4'h2);
        chk("bl.d2dp", 32'(dp_out), 32'd1);
        goto_k(253); chk_out("bl.f7off", 4'hF, 4'h3);
        goto_k(255); chk_out("bl.tickc", 4'hF, 4'h3);
        blink_tick = 1'b1;
        goto_k(256); blink_tick = 1'b0;
        chk_out("bl.on", 4'hD, 4'h3);

        // disable mid-show
        goto_k(284); chk_out("dis.pre", 4'hE, 4'h4);
        goto_k(285); en = 1'b0;
        goto_k(286); chk_out("dis.off", 4'hF, 4'h4);
        chk("dis.fd0", 32'(frame_done), 32'd0);
        goto_k(287); chk("dis.fd1", 32'(frame_done), 32'd0);
        goto_k(288); en = 1'b1;
        goto_k(289); chk_out("re.b1", 4'hF, 4'h4);
        goto_k(290); chk_out("re.b2", 4'hF, 4'h4);
        goto_k(291); chk_out("re.show", 4'hE, 4'h4);

        // async reset mid-slot
        goto_k(293); chk_out("ar.pre", 4'hE, 4'h4);
        #2 rst_n = 1'b0;
        #1;
        chk_out("ar.now", 4'hF, 4'h0);
        chk("ar.dp", 32'(dp_out), 32'd0);
        chk("ar.fd", 32'(frame_done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        k     = 0;
        goto_k(1); chk_out("ar.blank", 4'hF, 4'h4);
        goto_k(3); chk_out("ar.show", 4'hE, 4'h4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
